// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one word fetch at a time, and buffers
// returned words in a 2-entry FIFO for the decoder. Taken redirects flush and re-steer.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_discard;
  logic              r_misalign;
  logic [1:0]        r_count;
  logic [31:0]       r_head_instr;
  logic [ADDR_W-1:0] r_head_pc;
  logic [ADDR_W-1:0] r_head_pc4;
  logic [31:0]       r_tail_instr;
  logic [ADDR_W-1:0] r_tail_pc;

  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_count_after;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic [ADDR_W-1:0] w_req_pc4;
  logic [ADDR_W-1:0] w_tail_pc4;

  assign w_pop         = instr_valid && instr_ready;
  // A response is kept only when it belongs to the current stream and no redirect lands with it.
  assign w_push        = (r_state == S_WAIT) && imem_rvalid && !r_discard && !redirect_valid;
  assign w_count_after = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_redirect_pc = {redirect_target[ADDR_W-1:2], 2'b00};
  assign w_req_pc4     = r_req_pc + ADDR_W'(4);
  assign w_tail_pc4    = r_tail_pc + ADDR_W'(4);

  // Fetch control: PC, request FSM, discard flag for a stale outstanding response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_discard  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every read in this block sees pre-edge values.
      r_misalign <= redirect_valid && (redirect_target[1:0] != 2'b00);
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        case (r_state)
          S_IDLE: r_state <= S_REQ;
          S_REQ: begin
            if (imem_gnt) begin
              r_state   <= S_WAIT;
              r_discard <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              r_state   <= S_REQ;
              r_discard <= 1'b0;
            end else begin
              r_discard <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_count_after < 2'd2) r_state <= S_REQ;
          end
          S_REQ: begin
            if (imem_gnt) begin
              r_state    <= S_WAIT;
              r_req_pc   <= r_fetch_pc;
              r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              r_discard <= 1'b0;
              r_state   <= (w_count_after < 2'd2) ? S_REQ : S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Two-entry FIFO kept as head/tail registers so the decoder sees registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage is reset as well, so instr/instr_pc/pc_plus4 read zero out of reset.
      r_count      <= 2'd0;
      r_head_instr <= '0;
      r_head_pc    <= '0;
      r_head_pc4   <= '0;
      r_tail_instr <= '0;
      r_tail_pc    <= '0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      r_count <= w_count_after;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_instr <= imem_rdata;
            r_head_pc    <= r_req_pc;
            r_head_pc4   <= w_req_pc4;
          end else begin
            r_tail_instr <= imem_rdata;
            r_tail_pc    <= r_req_pc;
          end
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_head_pc4   <= w_tail_pc4;
          end
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_head_instr <= r_tail_instr;
            r_head_pc    <= r_tail_pc;
            r_head_pc4   <= w_tail_pc4;
            r_tail_instr <= imem_rdata;
            r_tail_pc    <= r_req_pc;
          end else begin
            r_head_instr <= imem_rdata;
            r_head_pc    <= r_req_pc;
            r_head_pc4   <= w_req_pc4;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req     = (r_state == S_REQ);
  assign imem_addr    = r_fetch_pc;
  assign instr_valid  = (r_count != 2'd0);
  assign instr        = r_head_instr;
  assign opcode       = r_head_instr[31:26];
  assign instr_pc     = r_head_pc;
  assign pc_plus4     = r_head_pc4;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: randomized memory/decoder/redirect stimulus checked against
// a stream model (expected PC sequence, re-seeded on redirect) plus directed scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready;
  logic        redirect_valid, misalign_err;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc_plus4, redirect_target;
  logic [5:0]  opcode;

  logic        hi_rst_n, hi_req, hi_rvalid, hi_valid, hi_mis;
  logic [31:0] hi_addr, hi_rdata, hi_instr, hi_pc, hi_pc4;
  logic [5:0]  hi_op;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .pc_plus4(pc_plus4), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .misalign_err(misalign_err));

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .reset_n(hi_rst_n), .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_gnt(1'b1), .imem_rvalid(hi_rvalid), .imem_rdata(hi_rdata),
    .instr_valid(hi_valid), .instr_ready(1'b1), .instr(hi_instr), .opcode(hi_op),
    .instr_pc(hi_pc), .pc_plus4(hi_pc4), .redirect_valid(1'b0),
    .redirect_target(32'h0), .misalign_err(hi_mis));

  int          n_tests = 0, n_fail = 0, n_deliv = 0;
  int          lat_min = 1, lat_max = 1;
  bit          gnt_rand = 1'b0;
  bit          pend = 1'b0, hi_pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0, hi_pend_addr = '0, exp_pc = '0, mon_word;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {a[7:2], a[27:2] ^ 26'h2AB_CDEF};
  endfunction

  // Memory model: grant is decided from mid-cycle values, response after lat cycles, in order.
  always @(negedge clk) begin
    if (imem_req && imem_gnt) begin
      pend      = 1'b1;
      pend_cnt  = int'($urandom_range(lat_max, lat_min));
      pend_addr = imem_addr;
    end
    hi_pend      = hi_req;
    hi_pend_addr = hi_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end
    end
    imem_gnt  = !pend && (gnt_rand ? ($urandom_range(1, 0) == 1) : 1'b1);
    hi_rvalid = hi_pend;
    hi_rdata  = mem_word(hi_pend_addr);
  end

  // Stream model: every word handed to the decoder must be the next sequential PC.
  always @(negedge clk) begin
    if (reset_n) begin
      if (instr_valid && instr_ready) begin
        mon_word = mem_word(exp_pc);
        n_tests++;
        if (instr_pc !== exp_pc || instr !== mon_word || opcode !== mon_word[31:26] ||
            pc_plus4 !== exp_pc + 32'd4) begin
          n_fail++;
          $display("FAIL stream: got pc=%h instr=%h op=%h pc4=%h, want pc=%h instr=%h op=%h pc4=%h",
                   instr_pc, instr, opcode, pc_plus4, exp_pc, mon_word, mon_word[31:26], exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      if (redirect_valid) exp_pc = {redirect_target[31:2], 2'b00};
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b0)     begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_tests++; if (instr_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    n_tests++; if (instr !== 32'h0)       begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_tests++; if (instr_pc !== 32'h0)    begin n_fail++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    n_tests++; if (pc_plus4 !== 32'h0)    begin n_fail++; $display("FAIL reset_pc4: got %h want 0", pc_plus4); end
  endtask

  task automatic test_basic_fetch();
    int ng = 0, gcyc = -1, vcyc = -1;
    lat_min = 1; lat_max = 1; gnt_rand = 1'b0;
    exp_pc = 32'h0;
    drive_edge();
    reset_n = 1'b1; instr_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        if (ng < 3) begin
          n_tests++;
          if (imem_addr !== 32'(ng * 4)) begin
            n_fail++; $display("FAIL fetch_addr%0d: got %h want %h", ng, imem_addr, 32'(ng * 4));
          end
        end
        if (ng == 0) gcyc = cyc;
        ng++;
      end
      if (instr_valid && vcyc < 0) begin
        vcyc = cyc;
        n_tests++;
        if (instr !== 32'h2008_0005 || opcode !== 6'h08 || instr_pc !== 32'h0) begin
          n_fail++; $display("FAIL first_word: got instr=%h op=%h pc=%h want 20080005/08/0", instr, opcode, instr_pc);
        end
      end
    end
    n_tests++;
    if (gcyc < 0 || vcyc != gcyc + 2) begin
      n_fail++; $display("FAIL fetch_latency: got grant@%0d valid@%0d want valid=grant+2", gcyc, vcyc);
    end
    n_tests++;
    if (ng < 15) begin n_fail++; $display("FAIL fetch_rate: got %0d grants want >=15", ng); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held = '0;
    drive_edge();
    instr_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 5) held = instr;
      if (cyc >= 5) begin
        n_tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== held) begin
          n_fail++; $display("FAIL stall_c%0d: got req=%b valid=%b instr=%h want 0/1/%h", cyc, imem_req, instr_valid, instr, held);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive_edge();
      instr_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL drain%0d: got valid=%b want 1", k, instr_valid); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_redirect_outstanding();
    bit found = 1'b0;
    drive_edge();
    lat_min = 3; lat_max = 3; instr_ready = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL redir_wait_grant: got timeout want grant"); end
    drive_edge();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    drive_edge();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_flush: got valid=%b req=%b want 0/0", instr_valid, imem_req);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        found = 1'b1;
        n_tests++;
        if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %h want 00000100", imem_addr); end
      end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL redir_refetch: got timeout want grant"); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        found = 1'b1;
        n_tests++;
        if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL redir_pc: got %h want 00000100", instr_pc); end
      end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL redir_deliver: got timeout want valid"); end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_redirect_pop_rvalid();
    bit found = 1'b0;
    drive_edge();
    lat_min = 1; lat_max = 1; instr_ready = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && instr_valid) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL coinc_setup: got timeout want grant with head"); end
    drive_edge();
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
    @(negedge clk);
    n_tests++;
    if (imem_rvalid !== 1'b1 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL coinc_align: got rvalid=%b valid=%b want 1/1", imem_rvalid, instr_valid);
    end
    drive_edge();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL coinc_flush: got valid=%b want 0", instr_valid); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        found = 1'b1;
        n_tests++;
        if (instr_pc !== 32'h200) begin n_fail++; $display("FAIL coinc_pc: got %h want 00000200", instr_pc); end
      end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL coinc_deliver: got timeout want valid"); end
  endtask

  task automatic test_misalign();
    bit found = 1'b0;
    drive_edge();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
    @(negedge clk);
    n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_early: got %b want 0", misalign_err); end
    drive_edge();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", misalign_err); end
    drive_edge();
    @(negedge clk);
    n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misalign_err); end
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        n_tests++;
        if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL mis_pc: got %h want 00000100", instr_pc); end
      end else begin
        @(negedge clk);
      end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL mis_deliver: got timeout want valid"); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] want_pc[3]  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] want_pc4[3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    int got = 0;
    drive_edge();
    hi_rst_n = 1'b1;
    for (int i = 0; i < 40 && got < 3; i++) begin
      @(negedge clk);
      if (hi_valid) begin
        n_tests++;
        if (hi_pc !== want_pc[got] || hi_pc4 !== want_pc4[got] || hi_instr !== mem_word(want_pc[got])) begin
          n_fail++; $display("FAIL wrap%0d: got pc=%h pc4=%h instr=%h want pc=%h pc4=%h instr=%h", got,
                             hi_pc, hi_pc4, hi_instr, want_pc[got], want_pc4[got], mem_word(want_pc[got]));
        end
        got++;
      end
    end
    n_tests++; if (got != 3) begin n_fail++; $display("FAIL wrap_count: got %0d words want 3", got); end
  endtask

  task automatic test_random();
    bit prev_redir = 1'b0, prev_mis = 1'b0, redir, mis;
    int start_deliv = n_deliv;
    drive_edge();
    gnt_rand = 1'b1; lat_min = 1; lat_max = 3;
    for (int cyc = 0; cyc < 800; cyc++) begin
      instr_ready     = ($urandom_range(3, 0) != 0);
      redir           = ($urandom_range(24, 0) == 0);
      redirect_valid  = redir;
      redirect_target = 32'($urandom_range(1023, 0));
      mis             = redir && (redirect_target[1:0] != 2'b00);
      @(negedge clk);
      n_tests++;
      if (misalign_err !== prev_mis || (prev_redir && instr_valid !== 1'b0)) begin
        n_fail++; $display("FAIL rand_redir_c%0d: got mis=%b valid=%b want mis=%b valid=%s", cyc,
                           misalign_err, instr_valid, prev_mis, prev_redir ? "0" : "any");
      end
      prev_redir = redir; prev_mis = mis;
      drive_edge();
    end
    redirect_valid = 1'b0; gnt_rand = 1'b0; lat_min = 1; lat_max = 1; instr_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (n_deliv - start_deliv < 50) begin
      n_fail++; $display("FAIL rand_progress: got %0d words want >=50", n_deliv - start_deliv);
    end
  endtask

  task automatic test_reset_midop();
    bit found = 1'b0;
    drive_edge();
    lat_min = 3; lat_max = 3; instr_ready = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && instr_valid) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rst_setup: got timeout want grant with head"); end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    exp_pc  = 32'h0;
    #1;
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0 ||
        instr !== 32'h0 || instr_pc !== 32'h0 || pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL rst_async: got req=%b valid=%b mis=%b instr=%h pc=%h pc4=%h want all 0",
                         imem_req, instr_valid, misalign_err, instr, instr_pc, pc_plus4);
    end
    drive_edge();
    drive_edge();
    reset_n = 1'b1; instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        found = 1'b1;
        n_tests++;
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
      end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rst_refetch: got timeout want grant"); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        found = 1'b1;
        n_tests++;
        if (instr_pc !== 32'h0 || instr !== 32'h2008_0005) begin
          n_fail++; $display("FAIL rst_first: got pc=%h instr=%h want 0/20080005", instr_pc, instr);
        end
      end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rst_deliver: got timeout want valid"); end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; hi_rst_n = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    hi_rvalid = 1'b0; hi_rdata = '0;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_pop_rvalid();
    test_misalign();
    test_pc_wrap();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
